// File: rtl/flow_slot_fifo.sv
// Per-flow slot-ID FIFO for the CCI-P transmit path: registered outputs, one-cycle pop
// latency, and a one-cycle error pulse for each push dropped on overflow.
module flow_slot_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int LOG_DEPTH  = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push_en,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop_enable,
   output logic                  pop_valid,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic [LOG_DEPTH-1:0]  pop_dw,
   output logic                  error
);

   localparam int DEPTH = 2 ** LOG_DEPTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [LOG_DEPTH-1:0]  wp_q, wp_d;
   logic [LOG_DEPTH-1:0]  rp_q, rp_d;
   logic [LOG_DEPTH-1:0]  cnt_q, cnt_d;
   logic                  pop_valid_q, pop_valid_d;
   logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
   logic                  error_q, error_d;

   logic full, empty, pop_acc, push_acc;

   // One slot is always left unused, so the count never needs more than LOG_DEPTH bits.
   assign full     = (cnt_q == LOG_DEPTH'(DEPTH - 1));
   assign empty    = (cnt_q == '0);
   assign pop_acc  = pop_enable && !empty;
   assign push_acc = push_en && (!full || pop_acc);

   // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      wp_d        = wp_q;
      rp_d        = rp_q;
      cnt_d       = cnt_q;
      pop_valid_d = pop_acc;
      pop_data_d  = pop_data_q;
      error_d     = push_en && !push_acc;
      if (push_acc) wp_d = wp_q + LOG_DEPTH'(1);
      if (pop_acc) begin
         rp_d       = rp_q + LOG_DEPTH'(1);
         pop_data_d = mem_q[rp_q];
      end
      if (push_acc && !pop_acc)      cnt_d = cnt_q + LOG_DEPTH'(1);
      else if (pop_acc && !push_acc) cnt_d = cnt_q - LOG_DEPTH'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp_q        <= '0;
         rp_q        <= '0;
         cnt_q       <= '0;
         pop_valid_q <= 1'b0;
         pop_data_q  <= '0;
         error_q     <= 1'b0;
      end else begin
         wp_q        <= wp_d;
         rp_q        <= rp_d;
         cnt_q       <= cnt_d;
         pop_valid_q <= pop_valid_d;
         pop_data_q  <= pop_data_d;
         error_q     <= error_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers and count decide what is valid.
   always_ff @(posedge clk) begin
      if (push_acc) mem_q[wp_q] <= push_data;
   end

   assign pop_valid = pop_valid_q;
   assign pop_data  = pop_data_q;
   assign pop_dw    = cnt_q;
   assign error     = error_q;

endmodule

// File: tb/tb_flow_slot_fifo.sv
// Self-checking bench for flow_slot_fifo: directed vector table, hand sequences
// for wrap-around and asynchronous reset, and random traffic against a queue model.
module tb_flow_slot_fifo;

   localparam int DW  = 8;
   localparam int LD  = 3;
   localparam int CAP = 2 ** LD - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          push_en;
   logic [DW-1:0] push_data;
   logic          pop_enable;
   logic          pop_valid;
   logic [DW-1:0] pop_data;
   logic [LD-1:0] pop_dw;
   logic          error;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural reference: a queue of stored entries plus the expected output registers.
   logic [DW-1:0] model_q[$];
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_err;

   typedef struct {
      logic          push;
      logic [DW-1:0] data;
      logic          pop;
      logic          exp_valid;
      logic [DW-1:0] exp_data;
      int            exp_dw;
      logic          exp_err;
   } vec_t;

   vec_t vecs[$];

   flow_slot_fifo #(.DATA_WIDTH(DW), .LOG_DEPTH(LD)) dut (
      .clk       (clk),
      .reset     (reset),
      .push_en   (push_en),
      .push_data (push_data),
      .pop_enable(pop_enable),
      .pop_valid (pop_valid),
      .pop_data  (pop_data),
      .pop_dw    (pop_dw),
      .error     (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      model_q.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_err   = 1'b0;
   endtask

   task automatic model_step(input logic p, input logic [DW-1:0] d, input logic o);
      bit pa, wa;
      pa = o && (model_q.size() > 0);
      wa = p && (model_q.size() < CAP || pa);
      m_valid = pa;
      m_err   = p && !wa;
      if (pa) m_data = model_q.pop_front();
      if (wa) model_q.push_back(d);
   endtask

   task automatic cycle(input logic p, input logic [DW-1:0] d, input logic o);
      push_en    = p;
      push_data  = d;
      pop_enable = o;
      @(posedge clk);
      #1;
      model_step(p, d, o);
      check("model_pop_valid", 32'(pop_valid), 32'(m_valid));
      check("model_pop_data",  32'(pop_data),  32'(m_data));
      check("model_pop_dw",    32'(pop_dw),    32'(model_q.size()));
      check("model_error",     32'(error),     32'(m_err));
   endtask

   task automatic add_vec(input logic p, input logic [DW-1:0] d, input logic o,
                          input logic ev, input logic [DW-1:0] ed, input int edw, input logic ee);
      vec_t v;
      v.push = p; v.data = d; v.pop = o;
      v.exp_valid = ev; v.exp_data = ed; v.exp_dw = edw; v.exp_err = ee;
      vecs.push_back(v);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Directed table: expected outputs are those seen just after each edge.
      add_vec(0, 8'h00, 1, 0, 8'h00, 0, 0);                       // pop on empty
      for (int i = 0; i < 7; i++) add_vec(1, 8'(8'h11 + i), 0, 0, 8'h00, i + 1, 0);
      add_vec(1, 8'hAA, 0, 0, 8'h00, 7, 1);                       // overflow drop
      add_vec(0, 8'h00, 0, 0, 8'h00, 7, 0);                       // error is a single pulse
      for (int i = 0; i < 7; i++) add_vec(0, 8'h00, 1, 1, 8'(8'h11 + i), 6 - i, 0);
      add_vec(0, 8'h00, 1, 0, 8'h17, 0, 0);                       // empty pop holds data
      add_vec(1, 8'h33, 1, 0, 8'h17, 1, 0);                       // push+pop on empty
      add_vec(0, 8'h00, 1, 1, 8'h33, 0, 0);
      for (int i = 0; i < 7; i++) add_vec(1, 8'(8'h61 + i), 0, 0, 8'h33, i + 1, 0);
      add_vec(1, 8'h44, 1, 1, 8'h61, 7, 0);                       // push+pop on full
      for (int i = 0; i < 6; i++) add_vec(0, 8'h00, 1, 1, 8'(8'h62 + i), 6 - i, 0);
      add_vec(0, 8'h00, 1, 1, 8'h44, 0, 0);                       // 0x44 emerges last

      push_en = 0; push_data = '0; pop_enable = 0;
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_pop_valid", 32'(pop_valid), 32'd0);
      check("reset_pop_dw",    32'(pop_dw),    32'd0);
      check("reset_error",     32'(error),     32'd0);
      check("reset_pop_data",  32'(pop_data),  32'd0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         cycle(vecs[i].push, vecs[i].data, vecs[i].pop);
         check($sformatf("vec%0d_pop_valid", i), 32'(pop_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d_pop_data", i),  32'(pop_data),  32'(vecs[i].exp_data));
         check($sformatf("vec%0d_pop_dw", i),    32'(pop_dw),    32'(vecs[i].exp_dw));
         check($sformatf("vec%0d_error", i),     32'(error),     32'(vecs[i].exp_err));
      end

      // Wrap-around: hold occupancy at 2-3 across 20 push/pop pairs.
      cycle(1, 8'hC0, 0);
      cycle(1, 8'hC1, 0);
      for (int i = 0; i < 20; i++) begin
         cycle(1, 8'(8'hC2 + i), 0);
         cycle(0, 8'h00, 1);
         check("wrap_order", 32'(pop_data), 32'(8'hC0 + i));
      end
      while (model_q.size() > 0) cycle(0, 8'h00, 1);
      check("wrap_drained", 32'(pop_dw), 32'd0);

      // Random traffic against the queue model.
      for (int i = 0; i < 600; i++)
         cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

      // Asynchronous reset between edges with 4 entries stored.
      while (model_q.size() > 0) cycle(0, 8'h00, 1);
      for (int i = 0; i < 4; i++) cycle(1, 8'(8'hE0 + i), 0);
      push_en = 0; pop_enable = 0;
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_pop_dw",     32'(pop_dw),    32'd0);
      check("async_reset_pop_valid",  32'(pop_valid), 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      cycle(0, 8'h00, 1);
      check("post_reset_pop_valid", 32'(pop_valid), 32'd0);
      cycle(1, 8'h55, 0);
      cycle(0, 8'h00, 1);
      check("post_reset_pop_valid2", 32'(pop_valid), 32'd1);
      check("post_reset_pop_data",   32'(pop_data),  32'h55);
      cycle(0, 8'h00, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
